// File: rtl/uart_cfg_responder.sv
// ---------------------------------------------------------------------------
// uart_cfg_responder
//
// Slave-side configuration responder for the UART link-setup protocol.
// After the main FSM pulses cfg_start_i, the block sends an 8'hFF
// acknowledgment. It then accepts configuration packets from the RX FIFO:
//   bits [1:0] id, bits [3:2] option, bits [7:4] ignored.
// The packets update a shadow copy of the configuration. Each legal packet
// is acknowledged with 8'hFF. The END packet (id 00) commits the shadow to
// config_o once its acknowledgment has been accepted.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   cfg_start_i           one-cycle session start pulse (honoured in IDLE only)
//   rx_data_i/valid_i     received byte stream, rx_ready_o accepts it
//   tx_data_o/valid_o     acknowledgment byte, tx_ready_i accepts it
//   config_o[5:0]         committed {data_width, stop_bits, parity_mode}
//   busy_o                session in progress
//   cfg_done_o            one-cycle pulse when the configuration is committed
//   cfg_error_o           one-cycle pulse when an illegal packet is received
//   cfg_timeout_o         one-cycle pulse when a session times out
//   int_id_o[3:0]         interrupt id alongside a status pulse, 0000 otherwise
//
// Build option:
//   UART_CFG_TIMEOUT_EN   when defined, abort a session after TIMEOUT_CYCLES
//                         idle cycles in WAIT_PKT. When undefined, no counter
//                         is built and cfg_timeout_o is tied to 0.
// ---------------------------------------------------------------------------
module uart_cfg_responder #(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cfg_start_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic [5:0] config_o,
    output logic       busy_o,
    output logic       cfg_done_o,
    output logic       cfg_error_o,
    output logic       cfg_timeout_o,
    output logic [3:0] int_id_o
);

    localparam logic [5:0] CFG_RESET  = 6'b11_01_00;
    localparam logic [3:0] INT_NONE   = 4'b0000;
    localparam logic [3:0] INT_ERROR  = 4'b0001;
    localparam logic [3:0] INT_DONE   = 4'b0110;
    localparam logic [7:0] ACK_BYTE   = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_ACKN,
        S_WAIT_PKT,
        S_DECODE,
        S_PKT_ACKN,
        S_COMMIT
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] shadow_q, shadow_d;
    logic [5:0] config_q, config_d;
    logic [3:0] pkt_q, pkt_d;       // only id and option are kept
    logic       end_q, end_d;       // END seen, commit after its acknowledgment
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic [3:0] int_id_q, int_id_d;
    logic       timeout_hit;        // WAIT_PKT idle limit reached this cycle

`ifdef UART_CFG_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    assign timeout_hit = (state_q == S_WAIT_PKT) && !rx_valid_i && (cnt_q == CNT_MAX);

    // Counts idle WAIT_PKT cycles; clears on an accept and whenever the
    // state is left, so every new wait starts from zero.
    always_comb begin
        cnt_d = '0;
        if (state_q == S_WAIT_PKT && state_d == S_WAIT_PKT && !rx_valid_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign timeout_d = timeout_hit;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign cfg_timeout_o = timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
    assign cfg_timeout_o  = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        config_d = config_q;
        pkt_d    = pkt_q;
        end_d    = end_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        int_id_d = INT_NONE;

        unique case (state_q)
            S_IDLE: begin
                if (cfg_start_i) begin
                    shadow_d = config_q;
                    end_d    = 1'b0;
                    state_d  = S_INIT_ACKN;
                end
            end
            S_INIT_ACKN: begin
                if (tx_ready_i) begin
                    state_d = S_WAIT_PKT;
                end
            end
            S_WAIT_PKT: begin
                // An accept takes priority over a simultaneous timeout.
                if (rx_valid_i) begin
                    pkt_d   = rx_data_i[3:0];
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    int_id_d = INT_ERROR;
                    state_d  = S_IDLE;
                end
            end
            S_DECODE: begin
                state_d = S_PKT_ACKN;
                unique case (pkt_q[1:0])
                    2'b01: shadow_d[5:4] = pkt_q[3:2];
                    2'b10: begin
                        if (pkt_q[3]) begin
                            // Reserved stop-bit option: abandon the session
                            // without acknowledging it.
                            error_d  = 1'b1;
                            int_id_d = INT_ERROR;
                            state_d  = S_IDLE;
                        end else begin
                            shadow_d[3:2] = pkt_q[3:2];
                        end
                    end
                    2'b11: shadow_d[1:0] = pkt_q[3:2];
                    default: end_d = 1'b1;
                endcase
            end
            S_PKT_ACKN: begin
                if (tx_ready_i) begin
                    if (end_q) begin
                        // Commit on the handshake edge so config_o and the
                        // done pulse appear in the first COMMIT cycle.
                        config_d = shadow_q;
                        done_d   = 1'b1;
                        int_id_d = INT_DONE;
                        state_d  = S_COMMIT;
                    end else begin
                        state_d = S_WAIT_PKT;
                    end
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            shadow_q <= CFG_RESET;
            config_q <= CFG_RESET;
            pkt_q    <= '0;
            end_q    <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            int_id_q <= INT_NONE;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            config_q <= config_d;
            pkt_q    <= pkt_d;
            end_q    <= end_d;
            done_q   <= done_d;
            error_q  <= error_d;
            int_id_q <= int_id_d;
        end
    end

    // Handshake outputs decode straight from the state register, so they
    // stay stable for as long as the state is held.
    assign tx_valid_o  = (state_q == S_INIT_ACKN) || (state_q == S_PKT_ACKN);
    assign tx_data_o   = tx_valid_o ? ACK_BYTE : 8'h00;
    assign rx_ready_o  = (state_q == S_WAIT_PKT);
    assign busy_o      = (state_q != S_IDLE);
    assign config_o    = config_q;
    assign cfg_done_o  = done_q;
    assign cfg_error_o = error_q;
    assign int_id_o    = int_id_q;

endmodule

// File: tb/tb_uart_cfg_responder.sv
module tb_uart_cfg_responder;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_start = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready = 1'b0;
    logic [5:0] config_o;
    logic       busy_o;
    logic       cfg_done_o;
    logic       cfg_error_o;
    logic       cfg_timeout_o;
    logic [3:0] int_id_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: committed configuration, and the packets of the
    // next session.
    logic [5:0] exp_cfg;
    logic [7:0] pkt_q[$];

    uart_cfg_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cfg_start_i  (cfg_start),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .rx_ready_o   (rx_ready_o),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready),
        .config_o     (config_o),
        .busy_o       (busy_o),
        .cfg_done_o   (cfg_done_o),
        .cfg_error_o  (cfg_error_o),
        .cfg_timeout_o(cfg_timeout_o),
        .int_id_o     (int_id_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Acknowledgment phase: stall tx_ready for a number of cycles, then
    // accept. Returns one cycle after the accepting edge.
    task automatic ack(input int stall);
        for (int i = 0; i < stall; i++) begin
            check("ack_stall_valid", tx_valid_o, 1);
            check("ack_stall_data", tx_data_o, 8'hFF);
            step();
        end
        tx_ready = 1'b1;
        check("ack_valid", tx_valid_o, 1);
        check("ack_data", tx_data_o, 8'hFF);
        step();
        tx_ready = 1'b0;
    endtask

    // Runs one session over pkt_q. 'idle' is the number of extra cycles spent
    // in WAIT_PKT before the first byte is offered.
    task automatic session(input int idle);
        logic [5:0] sh;
        logic [1:0] id, op;
        int dw, sb, pm;
        sh = exp_cfg;
        dw = sh[5:4]; sb = sh[3:2]; pm = sh[1:0];

        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check("init_valid", tx_valid_o, 1);
        check("init_data", tx_data_o, 8'hFF);
        check("init_busy", busy_o, 1);
        ack($urandom_range(0, 3));
        check("wait_ready", rx_ready_o, 1);

        if (idle == 0) begin
            // A start pulse mid-session must be ignored.
            cfg_start = 1'b1;
            step();
            cfg_start = 1'b0;
            check("start_ignored_rdy", rx_ready_o, 1);
            check("start_ignored_txv", tx_valid_o, 0);
        end else begin
            repeat (idle) step();
            check("late_ready", rx_ready_o, 1);
        end

        foreach (pkt_q[k]) begin
            id = pkt_q[k][1:0];
            op = pkt_q[k][3:2];
            rx_data  = pkt_q[k];
            rx_valid = 1'b1;
            step();
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            check("decode_rdy", rx_ready_o, 0);
            check("decode_txv", tx_valid_o, 0);
            step();
            if (id == 2 && op >= 2) begin
                check("err_pulse", cfg_error_o, 1);
                check("err_int", int_id_o, 4'b0001);
                check("err_txv", tx_valid_o, 0);
                check("err_cfg", config_o, exp_cfg);
                step();
                check("err_clear", cfg_error_o, 0);
                check("err_idle", busy_o, 0);
                $display("session: illegal %02h config=%06b", pkt_q[k], config_o);
                return;
            end
            if (id == 1) dw = op;
            if (id == 2) sb = op;
            if (id == 3) pm = op;
            check("pkt_ack_valid", tx_valid_o, 1);
            ack($urandom_range(0, 3));
            if (id == 0) begin
                exp_cfg = {2'(dw), 2'(sb), 2'(pm)};
                check("done_pulse", cfg_done_o, 1);
                check("done_int", int_id_o, 4'b0110);
                check("done_cfg", config_o, exp_cfg);
                step();
                check("done_clear", cfg_done_o, 0);
                check("done_int_clear", int_id_o, 0);
                check("done_idle", busy_o, 0);
                $display("session: commit config=%06b", config_o);
                return;
            end
            check("next_ready", rx_ready_o, 1);
            check("cfg_held", config_o, exp_cfg);
        end
    endtask

    initial begin
        exp_cfg = 6'b110100;
        #23;
        check("rst_cfg", config_o, 6'b110100);
        check("rst_busy", busy_o, 0);
        check("rst_int", int_id_o, 0);
        check("rst_txv", tx_valid_o, 0);
        rst_n = 1'b1;
        step();
        check("idle_cfg", config_o, 6'b110100);
        check("idle_rdy", rx_ready_o, 0);

        // Directed: 5-bit data, parity option 10, END.
        pkt_q = '{8'h01, 8'h0B, 8'h00};
        session(0);
        check("dir_commit", config_o, 6'b000110);

        // Directed: reserved stop-bit option.
        pkt_q = '{8'h0A};
        session(0);
        check("dir_err_cfg", config_o, 6'b000110);

        // Randomised sessions.
        for (int s = 0; s < 40; s++) begin
            int n;
            n = $urandom_range(0, 5);
            pkt_q.delete();
            for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom));
            pkt_q.push_back({4'($urandom), 4'b0000 | {2'($urandom), 2'b00}});
            session(0);
        end

`ifdef UART_CFG_TIMEOUT_EN
        // No byte after the init acknowledgment: timeout after TO cycles.
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        ack(0);
        repeat (TO - 1) step();
        check("to_last_ready", rx_ready_o, 1);
        check("to_not_yet", cfg_timeout_o, 0);
        step();
        check("to_pulse", cfg_timeout_o, 1);
        check("to_int", int_id_o, 4'b0001);
        check("to_idle", busy_o, 0);
        check("to_cfg", config_o, exp_cfg);
        step();
        check("to_clear", cfg_timeout_o, 0);
        $display("timeout: pulse seen after %0d wait cycles", TO);

        // A byte accepted on the last allowed cycle is decoded normally.
        pkt_q = '{8'h07, 8'h00};
        session(TO - 1);
`else
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        ack(0);
        repeat (3 * TO) step();
        check("no_to_ready", rx_ready_o, 1);
        check("no_to_pulse", cfg_timeout_o, 0);
        rx_data = 8'h00;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        step();
        ack(0);
        check("no_to_commit", cfg_done_o, 1);
        step();
        $display("no-timeout: session survived %0d idle cycles", 3 * TO);
`endif

        // Reset during a stalled acknowledgment.
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        ack(0);
        rx_data = 8'h05;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("stall_txv", tx_valid_o, 1);
            check("stall_data", tx_data_o, 8'hFF);
            step();
        end
        #1 rst_n = 1'b0;
        #1;
        exp_cfg = 6'b110100;
        check("arst_cfg", config_o, exp_cfg);
        check("arst_txv", tx_valid_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_int", int_id_o, 0);
        check("arst_rdy", rx_ready_o, 0);
        $display("reset: config=%06b busy=%0b", config_o, busy_o);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // Session after reset starts from the reset configuration.
        pkt_q = '{8'h0D, 8'h00};
        session(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_cfg_responder.md
# uart_cfg_responder

Slave-side configuration responder for the UART link-setup protocol. When the main controller has seen the master's initialisation signal, this block sends the acknowledgment packet and decodes incoming configuration packets (id in bits [1:0], option in bits [3:2], bits [7:4] ignored) into a shadow configuration. It acknowledges each legal packet and commits the shadow to the live configuration on the end-of-configuration packet. It sits between the RX FIFO output and the TX FIFO input, alongside the main control FSM.

## Interface
- Clock/reset: one clock; reset is asynchronous and active-low.

Parameters:
- `TIMEOUT_CYCLES`, default `5_000_000` (50 ms at 100 MHz): maximum idle cycles allowed between packets.

Ports:
- `clk_i` in 1: system clock
- `rst_n_i` in 1: asynchronous active-low reset
- `cfg_start_i` in 1: single-cycle pulse from the main FSM that starts a session
- `rx_data_i` in 8: received byte
- `rx_valid_i` in 1: received byte valid
- `rx_ready_o` out 1: block accepts the byte
- `tx_data_o` out 8: byte to transmit
- `tx_valid_o` out 1: transmit request
- `tx_ready_i` in 1: TX side accepts the byte
- `config_o` out 6: committed `{data_width, stop_bits, parity_mode}`
- `busy_o` out 1: session in progress
- `cfg_done_o` out 1: pulse, configuration committed
- `cfg_error_o` out 1: pulse, illegal packet received
- `cfg_timeout_o` out 1: pulse, session timed out
- `int_id_o` out 4: interrupt id, valid for one cycle alongside a status pulse; `INT_NONE` (0000) otherwise

## Operation
- States: IDLE, INIT_ACKN, WAIT_PKT, DECODE, PKT_ACKN, COMMIT.
- **IDLE**
  - `cfg_start_i` loads the shadow from `config_o` and moves to INIT_ACKN.
  - `cfg_start_i` is ignored in every state except IDLE.
- **INIT_ACKN / PKT_ACKN**
  - `tx_data_o` = 8'hFF and `tx_valid_o` = 1 until `tx_ready_i` is seen.
  - INIT_ACKN then goes to WAIT_PKT.
  - PKT_ACKN then goes to WAIT_PKT, or to COMMIT if the acknowledged packet was END.
- **WAIT_PKT**
  - `rx_ready_o` = 1.
  - On `rx_valid_i`, the byte is latched and the state moves to DECODE.
- **DECODE** (one cycle)
  - id 01: shadow.data_width ← option.
  - id 10: option 00/01 sets shadow.stop_bits; option 1x (reserved) is illegal.
  - id 11: shadow.parity_mode ← option (1x means parity disabled and is legal).
  - id 00: END, marks commit pending.
  - Legal packet goes to PKT_ACKN.
  - Illegal packet: shadow discarded, no acknowledgment sent, `cfg_error_o` pulses, `int_id_o` = 0001, go to IDLE.
- **COMMIT**
  - `config_o` ← shadow.
  - `cfg_done_o` pulses, `int_id_o` = 0110.
  - Go to IDLE.
- Repeated ids within one session: the last value wins.
- `config_o` changes only in COMMIT.
- `busy_o` = 1 in every state except IDLE.

## Timing
- Reset values:
  - `config_o` = {11, 01, 00} (8-bit data, 2 stop bits, even parity).
  - All other outputs 0; `int_id_o` = 0000.
  - State = IDLE.
- `cfg_start_i` at cycle N: `tx_valid_o` high at N+1.
- RX accept at cycle N: DECODE at N+1; then either `tx_valid_o` at N+2, or `cfg_error_o` at N+2.
- TX handshake completes at cycle M in PKT_ACKN:
  - Non-END packet: `rx_ready_o` at M+1.
  - END packet: `cfg_done_o` and new `config_o` at M+1.
- `tx_data_o` and `tx_valid_o` stay stable until accepted. The upstream holds `rx_data_i` while `rx_ready_o` = 0.
- All status pulses are exactly one cycle wide and registered.
- Asserting `rst_n_i` mid-session aborts immediately and restores the reset values, including `config_o`.

## Configuration
- Macro `UART_CFG_TIMEOUT_EN`.
- **Defined:**
  - A counter runs only in WAIT_PKT and clears on every RX accept and on leaving the state.
  - When it reaches `TIMEOUT_CYCLES-1` with no accept in that cycle, the block returns to IDLE, discards the shadow, pulses `cfg_timeout_o` and sets `int_id_o` = 0001.
  - An accept in the same cycle takes priority over the timeout.
- **Undefined:**
  - No counter is built.
  - WAIT_PKT waits indefinitely.
  - `cfg_timeout_o` is tied to 0.

## Test plan
- Reset with no stimulus -> `config_o` = 6'b110100, `busy_o` = 0, `int_id_o` = 0000.
- Pulse `cfg_start_i`, `tx_ready_i` = 1 -> one 8'hFF accepted, then `rx_ready_o` = 1.
- Send 8'h01 (5-bit), 8'h0B (id 11, option 10), 8'h00; each acknowledged with 8'hFF -> one cycle after the final acknowledgment, `config_o` = 6'b000110, `cfg_done_o` pulses, `int_id_o` = 0110.
- Send 8'h0A (stop bits reserved) -> no FF transmitted, `cfg_error_o` and `int_id_o` = 0001 at accept+2, `config_o` unchanged.
- With `UART_CFG_TIMEOUT_EN` defined and `TIMEOUT_CYCLES` = 16, send nothing after the init acknowledgment -> `cfg_timeout_o` pulses after 16 cycles in WAIT_PKT. A byte accepted on cycle 16 instead is decoded normally.
- Hold `tx_ready_i` = 0 for 5 cycles in PKT_ACKN, then assert `rst_n_i` -> `tx_valid_o` is stable throughout the stall, and all outputs return to their reset values asynchronously.
